data_sram_bridge: RTL and testbench

// Memory-stage bus bridge between the pipeline's byte-enable/store-data path and a

---
 rtl/data_sram_bridge.sv | 137 +++++++++++++
 tb/tb_data_sram_bridge.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_bridge.sv
// rtl/data_sram_bridge.sv - M-stage bridge onto a split-handshake SRAM-like data bus
module data_sram_bridge #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_wr,
  input  logic [3:0]  mem_wea,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        cpu_hold,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        bus_err,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Last counter value before a missing data_ok is declared a timeout.
  localparam logic [7:0] LP_LAST = 8'(MAX_WAIT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata;
  logic [1:0]  w_store_size;
  logic        w_capture;
  logic        w_timeout;

  // Bus size for a store follows the byte-enable pattern; odd patterns fall back to word.
  always_comb begin
    w_store_size = 2'd2;
    case (mem_wea)
      4'b1111:                            w_store_size = 2'd2;
      4'b0011, 4'b1100:                   w_store_size = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: w_store_size = 2'd0;
      default:                            w_store_size = 2'd2;
    endcase
  end

  // Next-state logic plus the capture/timeout strobes used by the register process.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_req) w_next = S_REQ;
      end
      S_REQ: begin
        if (data_addr_ok) begin
          if (data_data_ok) begin
            w_next    = S_DONE;
            w_capture = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (data_data_ok) begin
          w_next    = S_DONE;
          w_capture = 1'b1;
        end else if (r_cnt == LP_LAST) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end
      end
      S_DONE: begin
        if (!cpu_hold) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, latched request fields, wait counter and held read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_cnt   <= 8'd0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && mem_req) begin
        r_wr    <= mem_wr;
        r_size  <= mem_wr ? w_store_size : mem_size;
        r_addr  <= mem_addr;
        r_wdata <= mem_wdata;
      end
      if (r_state == S_REQ && data_addr_ok && !data_data_ok) begin
        r_cnt <= 8'd0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 8'd1;
      end
      // Stores never return data, so they leave zero behind.
      if (w_capture) begin
        r_rdata <= r_wr ? 32'd0 : data_rdata;
      end else if (w_timeout) begin
        r_rdata <= 32'd0;
      end
    end
  end

  assign data_req   = (r_state == S_REQ);
  assign data_wr    = r_wr;
  assign data_size  = r_size;
  assign data_addr  = r_addr;
  assign data_wdata = r_wdata;
  assign mem_rdata  = r_rdata;
  assign bus_err    = w_timeout;
  // Combinational so a fresh request stalls in the cycle it first appears.
  assign mem_stall  = mem_req & (r_state != S_DONE);

endmodule

// File: tb/tb_data_sram_bridge.sv
// tb/tb_data_sram_bridge.sv - randomized self-checking bench for data_sram_bridge
module tb_data_sram_bridge;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wea;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        bus_err;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] prev_rdata = 32'd0;
  logic [3:0]  wea_tab [8] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001,
                               4'b0010, 4'b0100, 4'b1000, 4'b0110};

  data_sram_bridge #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wea(mem_wea), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .bus_err(bus_err),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_size(input logic wr, input logic [3:0] wea,
                                          input logic [1:0] sz);
    if (!wr) return sz;
    if (wea == 4'b1111) return 2'd2;
    if (wea == 4'b0011 || wea == 4'b1100) return 2'd1;
    if ($countones(wea) == 1) return 2'd0;
    return 2'd2;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      mem_req      = 1'b0;
      cpu_hold     = 1'b0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'($urandom % 2);
      data_rdata   = $urandom;
      @(negedge clk);
      chk("idle_stall", 32'(mem_stall), 32'd0);
      chk("idle_req", 32'(data_req), 32'd0);
      chk("idle_err", 32'(bus_err), 32'd0);
      chk("idle_rdata", mem_rdata, prev_rdata);
      next_cycle();
    end
    data_data_ok = 1'b0;
  endtask

  task automatic check_fields(input string tag, input logic wr, input logic [1:0] esz,
                              input logic [31:0] addr, input logic [31:0] wdata);
    chk({tag, "_req"}, 32'(data_req), 32'd1);
    chk({tag, "_wr"}, 32'(data_wr), 32'(wr));
    chk({tag, "_size"}, 32'(data_size), 32'(esz));
    chk({tag, "_addr"}, data_addr, addr);
    chk({tag, "_wdata"}, data_wdata, wdata);
    chk({tag, "_stall"}, 32'(mem_stall), 32'd1);
    chk({tag, "_err"}, 32'(bus_err), 32'd0);
    chk({tag, "_rdata"}, mem_rdata, prev_rdata);
  endtask

  // One M-stage access: a_dly cycles without addr_ok, then the address handshake;
  // data_ok arrives with it (same) or at WAIT cycle d_idx, or never (tmo).
  task automatic run_txn(input logic wr, input logic [3:0] wea, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int a_dly, input bit same,
                         input int d_idx, input bit tmo, input int hold);
    logic [1:0]  esz;
    logic [31:0] erd;
    bit          got;
    esz = exp_size(wr, wea, sz);
    mem_req = 1'b1; mem_wr = wr; mem_wea = wea; mem_size = sz;
    mem_addr = addr; mem_wdata = wdata; cpu_hold = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    @(negedge clk);
    chk("accept_stall", 32'(mem_stall), 32'd1);
    chk("accept_req", 32'(data_req), 32'd0);
    next_cycle();
    // The bus must keep the latched copies even if the M-stage inputs move.
    mem_wr = ~wr; mem_wea = 4'($urandom); mem_size = 2'($urandom);
    mem_addr = $urandom; mem_wdata = $urandom;
    for (int i = 0; i < a_dly; i++) begin
      data_data_ok = 1'b0;
      @(negedge clk);
      check_fields("req_wait", wr, esz, addr, wdata);
      next_cycle();
    end
    data_addr_ok = 1'b1;
    data_data_ok = same;
    data_rdata   = rdata;
    @(negedge clk);
    check_fields("req_ack", wr, esz, addr, wdata);
    next_cycle();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    if (!same) begin
      got = 1'b0;
      for (int j = 0; j < MW && !got; j++) begin
        got = !tmo && (j == d_idx);
        data_data_ok = got;
        data_rdata   = got ? rdata : $urandom;
        @(negedge clk);
        chk("wait_req", 32'(data_req), 32'd0);
        chk("wait_stall", 32'(mem_stall), 32'd1);
        chk("wait_err", 32'(bus_err), 32'(tmo && (j == MW - 1)));
        chk("wait_rdata", mem_rdata, prev_rdata);
        next_cycle();
      end
      data_data_ok = 1'b0;
    end
    erd = (wr || tmo) ? 32'd0 : rdata;
    prev_rdata = erd;
    for (int k = 0; k <= hold; k++) begin
      cpu_hold   = (k < hold);
      data_rdata = $urandom;
      @(negedge clk);
      chk("done_stall", 32'(mem_stall), 32'd0);
      chk("done_req", 32'(data_req), 32'd0);
      chk("done_err", 32'(bus_err), 32'd0);
      chk("done_rdata", mem_rdata, erd);
      next_cycle();
    end
    mem_req  = 1'b0;
    cpu_hold = 1'b0;
  endtask

  initial begin
    reset = 1'b0; mem_req = 1'b0; mem_wr = 1'b0; mem_wea = 4'd0; mem_size = 2'd0;
    mem_addr = 32'd0; mem_wdata = 32'd0; cpu_hold = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_wr", 32'(data_wr), 32'd0);
    chk("rst_size", 32'(data_size), 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    chk("rst_wdata", data_wdata, 32'd0);
    next_cycle();
    reset = 1'b1;
    idle_gap(2);

    // Load word: addr_ok first REQ cycle, data_ok two cycles later.
    run_txn(1'b0, 4'b0000, 2'd2, 32'h0000_1000, 32'd0, 32'hDEAD_BEEF, 0, 1'b0, 1, 1'b0, 0);
    idle_gap(1);
    // Byte store with both handshakes together.
    run_txn(1'b1, 4'b0100, 2'd0, 32'h0000_2002, 32'h00AB_0000, 32'h1234_5678, 0, 1'b1, 0, 1'b0, 0);
    // Address handshake withheld for 5 cycles.
    run_txn(1'b0, 4'b0000, 2'd1, 32'h0000_3006, 32'd0, 32'hCAFE_F00D, 5, 1'b0, 0, 1'b0, 0);
    // data_ok never arrives.
    run_txn(1'b0, 4'b0000, 2'd2, 32'h0000_4000, 32'd0, 32'h5555_AAAA, 0, 1'b0, 0, 1'b1, 0);
    // data_ok on the last WAIT cycle beats the timeout.
    run_txn(1'b0, 4'b0000, 2'd0, 32'h0000_4001, 32'd0, 32'h0000_0077, 1, 1'b0, MW - 1, 1'b0, 0);
    // Held in DONE for 3 cycles while data_rdata keeps changing.
    run_txn(1'b0, 4'b0000, 2'd2, 32'h0000_5000, 32'd0, 32'h0BAD_C0DE, 0, 1'b1, 0, 1'b0, 3);
    // Back-to-back: next request in the cycle after DONE releases.
    run_txn(1'b1, 4'b1100, 2'd0, 32'h0000_6002, 32'hBEEF_0000, 32'h0, 0, 1'b1, 0, 1'b0, 0);

    // Reset during WAIT abandons the access; a late data_ok is ignored.
    mem_req = 1'b1; mem_wr = 1'b0; mem_size = 2'd2; mem_addr = 32'h0000_7000;
    next_cycle();
    data_addr_ok = 1'b1;
    next_cycle();
    data_addr_ok = 1'b0;
    next_cycle();
    reset = 1'b0; mem_req = 1'b0;
    next_cycle();
    reset = 1'b1;
    prev_rdata = 32'd0;
    for (int i = 0; i < 4; i++) begin
      data_data_ok = (i == 1);
      data_rdata   = 32'h9999_9999;
      @(negedge clk);
      chk("post_rst_stall", 32'(mem_stall), 32'd0);
      chk("post_rst_req", 32'(data_req), 32'd0);
      chk("post_rst_rdata", mem_rdata, 32'd0);
      chk("post_rst_addr", data_addr, 32'd0);
      next_cycle();
    end
    data_data_ok = 1'b0;

    for (int t = 0; t < 40; t++) begin
      logic wr;
      bit   same;
      bit   tmo;
      wr   = 1'($urandom % 2);
      same = ($urandom % 3) == 0;
      tmo  = !same && (($urandom % 4) == 0);
      run_txn(wr, wea_tab[$urandom % 8], 2'($urandom % 3), $urandom, $urandom, $urandom,
              int'($urandom % 4), same, int'($urandom % MW), tmo, int'($urandom % 3));
      idle_gap(int'($urandom % 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
